deser_16: RTL
=============

# deser_16

Sixteen-lane word deserializer: accepts a stream of W-bit words over a valid/ready handshake and packs them in arrival order into one N×W-bit frame presented on a valid/ready output. It is the inverse of the 16-to-1 lane mux (`mux_16`): lane k of the assembled frame occupies `out_data[W*k +: W]`, the same slice that `mux_16` returns for select value k. It sits between a narrow 16-bit producer and any consumer of the 256-bit lane bus.

## Interface
- `W`, 16, word and lane width in bits
- `N`, 16, lanes per frame; must be a power of two ≥ 2
- `clk`  in  1  rising-edge clock
- `rst`  in  1  asynchronous, active-high reset
- `clear`  in  1  synchronous abort of the frame being assembled
- `in_valid`  in  1  `in_data` is valid
- `in_ready`  out  1  block accepts `in_data` this cycle
- `in_data`  in  W  input word
- `out_valid`  out  1  a complete frame is held on `out_data`
- `out_ready`  in  1  consumer accepts the frame this cycle
- `out_data`  out  N*W  assembled frame; lane k = `out_data[W*k +: W]`
- `lane`  out  log2(N)  index of the lane the next accepted word will fill

## Operation
- Reset value of every output: `out_valid`=0, `lane`=0, `out_data`=0, `in_ready`=1.
- Input handshake: a word is accepted when `in_valid && in_ready`. Output handshake: a frame is taken when `out_valid && out_ready`.
- `in_ready` = `!out_valid || out_ready`, a combinational function of registered state and `out_ready`.
- States:
  - FILL: `out_valid`=0. Each accepted word is written to lane `lane`, and `lane` increments. When the word written is the one for lane N-1, `lane` wraps to 0 and the state goes to FULL.
  - FULL: `out_valid`=1 and `out_data` is stable. If `out_ready`=0, the block accepts nothing and holds. If `out_ready`=1, the frame is taken:
    - Without a simultaneous accepted word, go to FILL.
    - With a simultaneous accepted word, that word is written to lane 0, `lane` becomes 1, and the state goes to FILL. This gives back-to-back frames with no bubble.
- Lanes are written in place. While in FILL, lanes not yet rewritten keep stale data from the previous frame. `out_data` is meaningful only while `out_valid`=1.
- `clear` takes priority over both handshakes. On the next edge `lane` becomes 0 and `out_valid` becomes 0; a word presented in that cycle is dropped. `out_data` contents are not zeroed. While `clear`=1, `in_ready` is still driven by the normal equation, but nothing is written.
- `N`=2 is legal: the state goes to FULL after every second word.

## Timing
- `out_valid` rises on the clock edge that accepts the lane N-1 word, so it is visible in the cycle after that handshake.
- Minimum latency from first word accepted to `out_valid` is N cycles.
- Sustained throughput is one word per cycle, with `out_ready` held at 1 and no idle cycles between frames.
- `out_data` and `out_valid` are registered with no combinational path from the inputs. `in_ready` has one combinational path, from `out_ready`.
- Asserting `rst` mid-frame immediately forces the reset values. After deassertion the first accepted word goes to lane 0.
- No X on any output after reset, whatever the input values.

## Test plan
- Reset, then stream words 0x0000..0x000F with `in_valid`=1 and `out_ready`=0 → `out_valid` rises after the 16th accept. `out_data[16*k +: 16]` = k for every k. `in_ready`=0 while the frame is held.
- Hold the full frame for 5 cycles, then pulse `out_ready` with no input → `out_data` stays stable during the hold. `out_valid` drops on the next edge and `lane`=0.
- Two frames back-to-back (0x1000..0x100F, then 0x2000..0x200F) with `out_ready`=1 throughout → `out_valid` is high for exactly one cycle per frame. Frame 2 lane 0 = 0x2000 is accepted in the same cycle frame 1 is taken. 32 words complete in 33 cycles.
- Accept 7 words, assert `clear` while `in_valid`=1 with 0xDEAD → 0xDEAD is not written and `lane`=0. The next 16 words 0xA000..0xA00F yield a frame with lane 0 = 0xA000.
- Assert `rst` asynchronously after 9 words, mid-cycle → `out_valid`, `lane` and `out_data` go to 0 before the next edge. A following full frame assembles correctly.
- Loopback: feed each frame's `out_data` into `mux_16` and sweep its select 0..15 → `mux_16` output equals the k-th word sent, for random data across 100 frames with random `in_valid`/`out_ready` stalls.

Source files
------------

// File: rtl/deser_16.sv
// -----------------------------------------------------------------------------
// deser_16 : sixteen-lane word deserializer
//
// Packs a stream of W-bit words, in arrival order, into one N*W-bit frame.
// Lane k of the frame lives in o_out_data[W*k +: W], matching the select
// value k of the companion 16-to-1 lane mux.
//
// Ports
//   i_clk        rising-edge clock
//   i_rst        asynchronous active-high reset
//   i_clear      synchronous abort of the frame being assembled
//   i_in_valid   i_in_data carries a word
//   o_in_ready   a word is accepted this cycle when i_in_valid is also high
//   i_in_data    input word (W bits)
//   o_out_valid  a complete frame is held on o_out_data
//   i_out_ready  consumer takes the frame this cycle
//   o_out_data   assembled frame (N*W bits)
//   o_lane       lane the next accepted word will fill
// -----------------------------------------------------------------------------
module deser_16 #(
  parameter int W = 16,
  parameter int N = 16
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_clear,
  input  logic                   i_in_valid,
  output logic                   o_in_ready,
  input  logic [W-1:0]           i_in_data,
  output logic                   o_out_valid,
  input  logic                   i_out_ready,
  output logic [N*W-1:0]         o_out_data,
  output logic [$clog2(N)-1:0]   o_lane
);

  localparam int LW = $clog2(N);

  typedef enum logic {
    S_FILL = 1'b0,
    S_FULL = 1'b1
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [LW-1:0]   r_lane;
  logic [LW-1:0]   w_lane_nxt;
  logic [N*W-1:0]  r_data;
  logic            w_wr_en;
  logic            w_in_ready;
  logic            w_accept;

  // The only combinational input-to-output path: ready follows out_ready
  // while a frame is held.
  assign w_in_ready = (r_state == S_FILL) || i_out_ready;
  assign w_accept   = i_in_valid && w_in_ready;

  // State and lane pointer register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_FILL;
      r_lane  <= {LW{1'b0}};
    end else begin
      r_state <= w_state_nxt;
      r_lane  <= w_lane_nxt;
    end
  end

  // Next-state, next-lane and lane write enable.
  always_comb begin
    w_state_nxt = r_state;
    w_lane_nxt  = r_lane;
    w_wr_en     = 1'b0;
    if (i_clear) begin
      // Abort wins over both handshakes; the presented word is dropped.
      w_state_nxt = S_FILL;
      w_lane_nxt  = {LW{1'b0}};
    end else begin
      case (r_state)
        S_FILL: begin
          if (w_accept) begin
            w_wr_en = 1'b1;
            if (r_lane == LW'(N - 1)) begin
              w_lane_nxt  = {LW{1'b0}};
              w_state_nxt = S_FULL;
            end else begin
              w_lane_nxt  = r_lane + LW'(1);
            end
          end else begin
            w_state_nxt = S_FILL;
          end
        end
        S_FULL: begin
          if (i_out_ready) begin
            w_state_nxt = S_FILL;
            if (w_accept) begin
              // Back-to-back: r_lane is 0 here, so this word opens the
              // next frame in lane 0 without a bubble.
              w_wr_en    = 1'b1;
              w_lane_nxt = LW'(1);
            end else begin
              w_lane_nxt = {LW{1'b0}};
            end
          end else begin
            w_state_nxt = S_FULL;
          end
        end
        default: begin
          w_state_nxt = S_FILL;
          w_lane_nxt  = {LW{1'b0}};
        end
      endcase
    end
  end

  // Frame storage: lanes are overwritten in place, never bulk-cleared
  // except by reset.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_data <= {(N*W){1'b0}};
    end else begin
      for (int k = 0; k < N; k++) begin
        if (w_wr_en && (r_lane == LW'(k))) begin
          r_data[W*k +: W] <= i_in_data;
        end
      end
    end
  end

  assign o_in_ready  = w_in_ready;
  assign o_out_valid = (r_state == S_FULL);
  assign o_out_data  = r_data;
  assign o_lane      = r_lane;

endmodule
